// File: rtl/logic_mux_pkg.sv
// Shared types and constants for the truth-table sweeper around Logic_mux2.
//   sweep_state_t : sweeper FSM states
//   NUM_COMBOS    : number of {a,b,c} input combinations
//   LOGIC_MUX2_TT : known-good truth table of y = a ? b : (b | ~c), bit i = y for {a,b,c} = i
package logic_mux_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } sweep_state_t;

    localparam int unsigned NUM_COMBOS    = 8;
    localparam logic [7:0]  LOGIC_MUX2_TT = 8'hCD;

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// settle_timer: 4-bit up-counter that times how long each stimulus combination is held.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   i_clear  : reload the count to 0 (wins over i_en)
//   i_en     : count up by one this cycle
//   o_tc     : count has reached SETTLE_CYCLES-1
module settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [3:0] TC_VALUE = 4'(SETTLE_CYCLES - 1);

    logic [3:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 4'd0;
        end else if (i_clear) begin
            r_count <= 4'd0;
        end else if (i_en) begin
            r_count <= r_count + 4'd1;
        end
    end

    assign o_tc = (r_count == TC_VALUE);

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks {a,b,c} through all 8 combinations, waits SETTLE_CYCLES per
// combination, captures y into an 8-bit truth table and grades it against EXPECTED_TT.
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   start             : begin a sweep (honoured in IDLE or DONE only)
//   a, b, c           : registered stimulus, {a,b,c} = combination index
//   y                 : result from the logic stage under test
//   busy, done, pass  : sweep in progress / finished / finished with no mismatches
//   truth_table       : captured y, bit i = combination i
//   mismatch_count    : number of captured bits differing from EXPECTED_TT
//   first_fail_idx/_valid : lowest mismatching index and its qualifier
module truth_table_sweeper
    import logic_mux_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [7:0]  EXPECTED_TT   = LOGIC_MUX2_TT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] truth_table,
    output logic [3:0] mismatch_count,
    output logic [2:0] first_fail_idx,
    output logic       first_fail_valid
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_COMBOS - 1);

    sweep_state_t r_state;
    sweep_state_t w_state_next;

    logic [2:0] r_idx;
    logic [2:0] r_abc;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [7:0] r_tt;
    logic [3:0] r_mm_cnt;
    logic [2:0] r_ff_idx;
    logic       r_ff_valid;

    logic w_launch;
    logic w_timer_clr;
    logic w_timer_en;
    logic w_timer_tc;
    logic w_mismatch;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .i_clear(w_timer_clr),
        .i_en   (w_timer_en),
        .o_tc   (w_timer_tc)
    );

    assign w_mismatch = (y != EXPECTED_TT[r_idx]);

    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        w_timer_clr  = 1'b0;
        w_timer_en   = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_launch     = 1'b1;
                    w_timer_clr  = 1'b1;
                    w_state_next = SETTLE;
                end
            end
            SETTLE: begin
                w_timer_en = 1'b1;
                if (w_timer_tc) begin
                    w_state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                if (r_idx == LAST_IDX) begin
                    w_state_next = DONE;
                end else begin
                    w_timer_clr  = 1'b1;
                    w_state_next = SETTLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= 3'd0;
            r_abc      <= 3'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_tt       <= 8'd0;
            r_mm_cnt   <= 4'd0;
            r_ff_idx   <= 3'd0;
            r_ff_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_launch) begin
                r_idx      <= 3'd0;
                r_abc      <= 3'd0;
                r_busy     <= 1'b1;
                r_done     <= 1'b0;
                r_pass     <= 1'b0;
                r_tt       <= 8'd0;
                r_mm_cnt   <= 4'd0;
                r_ff_idx   <= 3'd0;
                r_ff_valid <= 1'b0;
            end else begin
                case (r_state)
                    SAMPLE: begin
                        r_tt[r_idx] <= y;
                        if (w_mismatch) begin
                            r_mm_cnt <= r_mm_cnt + 4'd1;
                            if (!r_ff_valid) begin
                                r_ff_idx   <= r_idx;
                                r_ff_valid <= 1'b1;
                            end
                        end
                        // The last index exits to DONE, so idx never wraps.
                        if (r_idx != LAST_IDX) begin
                            r_idx <= r_idx + 3'd1;
                            r_abc <= r_idx + 3'd1;
                        end
                    end
                    DONE: begin
                        // Status registers settle one cycle after the final sample.
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_pass <= (r_mm_cnt == 4'd0);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign {a, b, c}        = r_abc;
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign truth_table      = r_tt;
    assign mismatch_count   = r_mm_cnt;
    assign first_fail_idx   = r_ff_idx;
    assign first_fail_valid = r_ff_valid;

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

    typedef struct {
        logic [7:0] tt;
        logic [3:0] mm;
        logic [2:0] ffi;
        logic       ffv;
        logic       pass;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start3;

    logic       a, b, c, y, busy, done, pass, ffv;
    logic [7:0] tt;
    logic [3:0] mm;
    logic [2:0] ffi;

    logic       a3, b3, c3, y3, busy3, done3, pass3, ffv3;
    logic [7:0] tt3;
    logic [3:0] mm3;
    logic [2:0] ffi3;

    int   y_mode;  // 0: real mux, 1: tied low, 2: inverted mux
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    function automatic logic mux_ref(input logic ia, input logic ib, input logic ic);
        return ia ? ib : (ib | ~ic);
    endfunction

    assign y  = (y_mode == 0) ? mux_ref(a, b, c) :
                (y_mode == 1) ? 1'b0 : ~mux_ref(a, b, c);
    assign y3 = mux_ref(a3, b3, c3);

    truth_table_sweeper dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .a               (a),
        .b               (b),
        .c               (c),
        .y               (y),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .truth_table     (tt),
        .mismatch_count  (mm),
        .first_fail_idx  (ffi),
        .first_fail_valid(ffv)
    );

    truth_table_sweeper #(
        .SETTLE_CYCLES(3)
    ) dut3 (
        .clk             (clk),
        .rst             (rst),
        .start           (start3),
        .a               (a3),
        .b               (b3),
        .c               (c3),
        .y               (y3),
        .busy            (busy3),
        .done            (done3),
        .pass            (pass3),
        .truth_table     (tt3),
        .mismatch_count  (mm3),
        .first_fail_idx  (ffi3),
        .first_fail_valid(ffv3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Independent model: evaluate every combination and grade against the golden table.
    function automatic exp_t predict(input int mode);
        exp_t       e;
        logic [7:0] golden;
        logic [2:0] v;
        logic       yi;
        golden = 8'hCD;
        e.tt   = 8'd0;
        e.mm   = 4'd0;
        e.ffi  = 3'd0;
        e.ffv  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            v  = 3'(i);
            yi = mux_ref(v[2], v[1], v[0]);
            if (mode == 1) yi = 1'b0;
            if (mode == 2) yi = ~yi;
            e.tt[i] = yi;
            if (yi != golden[i]) begin
                e.mm = e.mm + 4'd1;
                if (!e.ffv) begin
                    e.ffi = v;
                    e.ffv = 1'b1;
                end
            end
        end
        e.pass = (e.mm == 4'd0);
        return e;
    endfunction

    task automatic compare_result(input string pfx, input logic [7:0] got_tt,
                                  input logic [3:0] got_mm, input logic [2:0] got_ffi,
                                  input logic got_ffv, input logic got_pass);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({pfx, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check({pfx, "_tt"},   32'(got_tt),   32'(e.tt));
        check({pfx, "_mm"},   32'(got_mm),   32'(e.mm));
        check({pfx, "_ffi"},  32'(got_ffi),  32'(e.ffi));
        check({pfx, "_ffv"},  32'(got_ffv),  32'(e.ffv));
        check({pfx, "_pass"}, 32'(got_pass), 32'(e.pass));
    endtask

    // Sweep on the default-parameter DUT; optionally fires start at edges 3 and 9 (busy).
    task automatic run_sweep(input int mode, input bit busy_pulses);
        int done_edge;
        int exp_abc;
        y_mode = mode;
        exp_q.push_back(predict(mode));
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);  // edge 0
        #1;
        start = 1'b0;
        check("launch_busy", 32'(busy), 32'd1);
        check("launch_done", 32'(done), 32'd0);
        check("launch_pass", 32'(pass), 32'd0);
        check("launch_abc",  32'({a, b, c}), 32'd0);
        check("launch_mm",   32'(mm), 32'd0);
        done_edge = -1;
        for (int n = 1; n <= 60 && done_edge < 0; n++) begin
            if (busy_pulses && (n == 3 || n == 9)) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            exp_abc = (n < 16) ? n / 2 : 7;
            check($sformatf("abc@%0d", n), 32'({a, b, c}), 32'(exp_abc));
            if (done) done_edge = n;
        end
        check("done_edge", 32'(done_edge), 32'd17);
        check("done_busy", 32'(busy), 32'd0);
        compare_result($sformatf("m%0d", mode), tt, mm, ffi, ffv, pass);
    endtask

    initial begin
        int done_edge;
        int exp_abc;
        rst    = 1'b1;
        start  = 1'b0;
        start3 = 1'b0;
        y_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_abc",  32'({a, b, c}), 32'd0);
        check("rst_tt",   32'(tt), 32'd0);
        check("rst_ffv",  32'(ffv), 32'd0);
        rst = 1'b0;

        run_sweep(0, 1'b0);  // real mux
        run_sweep(1, 1'b0);  // y tied low, restart from DONE
        run_sweep(2, 1'b0);  // inverted mux

        // Mid-sweep reset sampled at edge 7.
        y_mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("pre_rst_tt", 32'(tt), 32'h05);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_abc",  32'({a, b, c}), 32'd0);
        check("midrst_tt",   32'(tt), 32'd0);
        check("midrst_mm",   32'(mm), 32'd0);
        check("midrst_ffi",  32'(ffi), 32'd0);
        check("midrst_ffv",  32'(ffv), 32'd0);
        @(posedge clk);
        #1;
        check("idle_hold_busy", 32'(busy), 32'd0);

        // Simultaneous reset and start: reset wins.
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("rst_start_busy", 32'(busy), 32'd0);
        check("rst_start_abc",  32'({a, b, c}), 32'd0);

        run_sweep(0, 1'b0);  // clean sweep after reset
        run_sweep(0, 1'b1);  // start while busy ignored

        // SETTLE_CYCLES = 3 instance.
        exp_q.push_back(predict(0));
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        done_edge = -1;
        for (int n = 1; n <= 80 && done_edge < 0; n++) begin
            @(posedge clk);
            #1;
            exp_abc = (n < 32) ? n / 4 : 7;
            check($sformatf("s3_abc@%0d", n), 32'({a3, b3, c3}), 32'(exp_abc));
            if (done3) done_edge = n;
        end
        check("s3_done_edge", 32'(done_edge), 32'd33);
        compare_result("s3", tt3, mm3, ffi3, ffv3, pass3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
